// File: rtl/trace_sequencer.sv
// Sequences one 4x4 spell trace from a random bit stream, applies the grid
// connectivity rule per cell, retries rejected traces and presents the result.
module trace_sequencer #(
    parameter int MIN_CELLS = 4,
    parameter int MAX_RETRY = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rbg,
    input  logic        rbg_valid,
    output logic        rbg_req,
    output logic [15:0] trace,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [7:0]  trace_count,
    output logic        busy,
    output logic        fail
);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [1:0] {IDLE, FILL, CHECK, PRESENT} state_t;

    state_t          state;
    state_t          state_nx;
    logic [15:0]     work;
    logic [3:0]      k;
    logic [RW-1:0]   retry;
    logic            cell_bit;
    logic            accept;
    logic            retry_left;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // A cell below row 0 survives only if connected to the cell above or,
    // away from column 0, to the cell just written on its left.
    always_comb begin
        cell_bit = rbg;
        if (k >= 4'd4) begin
            cell_bit = rbg & (work[k - 4'd4] | ((k[1:0] != 2'd0) & work[k - 4'd1]));
        end
    end

    assign accept     = (popcount16(work) >= 5'(MIN_CELLS)) && (work[15:12] != 4'd0);
    assign retry_left = retry < RW'(MAX_RETRY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = FILL;
            FILL:    if (rbg_valid && k == 4'd15) state_nx = CHECK;
            CHECK:   state_nx = (accept || !retry_left) ? PRESENT : FILL;
            PRESENT: if (trace_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            work        <= '0;
            k           <= '0;
            retry       <= '0;
            trace       <= '0;
            fail        <= 1'b0;
            trace_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= '0;
                        k     <= '0;
                        retry <= '0;
                        fail  <= 1'b0;
                    end
                end
                FILL: begin
                    if (rbg_valid) begin
                        work[k] <= cell_bit;
                        k       <= k + 4'd1;
                    end
                end
                CHECK: begin
                    if (accept) begin
                        trace <= work;
                        fail  <= 1'b0;
                    end else if (retry_left) begin
                        retry <= retry + 1'b1;
                        work  <= '0;
                        k     <= '0;
                    end else begin
                        // Fallback: a single connected column 0.
                        trace <= 16'h1111;
                        fail  <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (trace_ready) trace_count <= trace_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign rbg_req     = (state == FILL);
    assign busy        = (state != IDLE);
    assign trace_valid = (state == PRESENT);
endmodule

// File: doc/trace_sequencer.md
# trace_sequencer

Controller that sequences construction of one 4x4 spell trace from a stream of random bits, validates it, and hands it to game logic over a valid/ready handshake. Sits between the random bit generator (RBG) and the game-state logic. Requests bits only while filling, applies the grid-connectivity rule cell by cell, and regenerates a rejected trace up to a retry limit. After the limit it substitutes a fixed fallback trace.

## Interface
- MIN_CELLS, 4: minimum number of set cells for a trace to be accepted (1..16).
- MAX_RETRY, 7: regenerations allowed after the first attempt; total attempts = MAX_RETRY+1.

- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a new trace; sampled only in IDLE.
- rbg  in  1  random bit.
- rbg_valid  in  1  rbg is valid this cycle.
- rbg_req  out  1  sequencer consumes rbg this cycle when rbg_valid is high.
- trace  out  16  presented trace; bit k is the cell at row k/4, column k%4.
- trace_valid  out  1  trace is available.
- trace_ready  in  1  consumer accepts the trace.
- trace_count  out  8  number of traces delivered; wraps 255->0.
- busy  out  1  state is not IDLE.
- fail  out  1  presented trace is the fallback.

## Operation
- States: IDLE, FILL, CHECK, PRESENT.
- IDLE:
  - start=1 -> FILL.
  - On that transition: work register cleared, cell index k=0, retry count=0, fail=0.
- FILL:
  - rbg_req=1.
  - On each edge with rbg_valid=1, work[k] is written, then k increments.
  - Cycles with rbg_valid=0 hold all state.
- Cell rule (c=k%4):
  - Row 0 (k<4): work[k]=rbg.
  - Rows 1-3: work[k] = rbg AND (work[k-4] OR (c!=0 AND work[k-1])).
  - work[k-1] refers to the value written on the previous accepted bit.
- After cell 15 is written: -> CHECK.
- CHECK (one cycle):
  - Accept when popcount(work) >= MIN_CELLS and work[15:12] != 0.
  - Accept -> PRESENT; trace <= work, fail <= 0.
  - Reject with retry count < MAX_RETRY -> FILL; retry count +1, work cleared, k=0.
  - Reject with retry count == MAX_RETRY -> PRESENT; trace <= 16'h1111 (column 0), fail <= 1.
- PRESENT:
  - trace_valid=1.
  - On an edge with trace_ready=1: trace_count +1, -> IDLE.
- Held values:
  - trace and fail hold after the handshake until the next PRESENT load.
  - fail clears on the next accepted start.
- start is ignored outside IDLE.
- trace_ready is ignored outside PRESENT.
- Reset (any state, including mid-FILL or PRESENT):
  - State returns to IDLE; k, work, and retry count clear.
  - trace=0, trace_valid=0, trace_count=0, busy=0, fail=0, rbg_req=0.
- popcount is 5 bits wide; the retry counter is wide enough for MAX_RETRY (4 bits at default).

## Timing
- start sampled at edge E0 -> FILL after E0.
- With rbg_valid held high, cells 0..15 are captured at E1..E16 and the state is CHECK after E16.
- trace_valid rises after E17, a minimum latency of 17 cycles.
- Each retry adds 17 cycles: 16 fill plus 1 check.
- Each low cycle of rbg_valid during FILL adds exactly one cycle.
- rbg_req, busy and trace_valid are registered state decodes; they are not combinational from inputs.
- trace is stable for the whole time trace_valid is high.
- Transfer occurs on the first edge with trace_valid AND trace_ready:
  - trace_valid falls after that edge; trace_count updates at the same edge.
- Back-to-back requests:
  - start may be high in the cycle after the handshake (IDLE) and is accepted there.
  - start must not be high during PRESENT; if it is, it is ignored.

## Test plan
- rbg_valid=1, rbg all ones, start pulse -> trace=16'hFFFF, trace_valid after 17 edges, fail=0, trace_count=1.
- Row 0 bits 0,1,0,0 (cells 0..3), then all ones -> trace=16'hEEE2 (popcount 10), accepted first attempt.
- First fill all zeros, second fill all ones -> one retry, trace=16'hFFFF at 34 edges after start, fail=0.
- rbg held 0, MAX_RETRY=7 -> 8 fills, trace=16'h1111 with fail=1 after 136 edges; next start clears fail.
- Backpressure:
  - trace_ready low 5 cycles after trace_valid -> trace stable, start pulses ignored, count increments once.
  - rbg_valid toggling 1/0 -> latency 33.
- Assert reset at k=7 in FILL -> all outputs at reset values next cycle; a fresh start then produces a normal 17-cycle trace.
